// File: rtl/label_pkg.sv
// Shared constants, widths and FSM encoding for the label bounding-box reader.
package label_pkg;

  localparam int DEF_PIC_COLS = 320;
  localparam int DEF_PIC_ROWS = 240;
  localparam int DEF_LBL_W    = 32;
  localparam int DEF_NLBL     = 16;

  localparam int ADDR_W    = 17;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int CNT_W     = 17;
  localparam int LBL_IDX_W = 4;

  localparam logic [DEF_LBL_W-1:0] BG_LABEL = '0;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    EMIT,
    FIN
  } state_e;

endpackage

// File: rtl/label_bbox_table.sv
// Per-label slot table: pixel count plus inclusive column/row bounds.
module label_bbox_table
  import label_pkg::*;
#(
  parameter int NLBL    = DEF_NLBL,
  parameter int CNT_MAX = DEF_PIC_COLS * DEF_PIC_ROWS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 upd_i,
  input  logic [LBL_IDX_W-1:0] upd_lbl_i,
  input  logic [X_W-1:0]       upd_x_i,
  input  logic [Y_W-1:0]       upd_y_i,
  input  logic [LBL_IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o,
  output logic [X_W-1:0]       rd_xmin_o,
  output logic [X_W-1:0]       rd_xmax_o,
  output logic [Y_W-1:0]       rd_ymin_o,
  output logic [Y_W-1:0]       rd_ymax_o
);

  logic [CNT_W-1:0] cnt_q  [NLBL];
  logic [X_W-1:0]   xmin_q [NLBL];
  logic [X_W-1:0]   xmax_q [NLBL];
  logic [Y_W-1:0]   ymin_q [NLBL];
  logic [Y_W-1:0]   ymax_q [NLBL];

  logic [CNT_W-1:0] upd_cnt;
  logic             upd_first;

  assign upd_cnt   = cnt_q[upd_lbl_i];
  assign upd_first = (upd_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NLBL; i++) cnt_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NLBL; i++) cnt_q[i] <= '0;
    end else if (upd_i) begin
      // Saturate rather than wrap: a full frame of one label is the ceiling.
      if (upd_cnt != CNT_W'(CNT_MAX)) cnt_q[upd_lbl_i] <= upd_cnt + 1'b1;
    end
  end

  // Bounds are only meaningful while the count is non-zero, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_i) begin
      if (upd_first) begin
        xmin_q[upd_lbl_i] <= upd_x_i;
        xmax_q[upd_lbl_i] <= upd_x_i;
        ymin_q[upd_lbl_i] <= upd_y_i;
        ymax_q[upd_lbl_i] <= upd_y_i;
      end else begin
        if (upd_x_i < xmin_q[upd_lbl_i]) xmin_q[upd_lbl_i] <= upd_x_i;
        if (upd_x_i > xmax_q[upd_lbl_i]) xmax_q[upd_lbl_i] <= upd_x_i;
        if (upd_y_i < ymin_q[upd_lbl_i]) ymin_q[upd_lbl_i] <= upd_y_i;
        if (upd_y_i > ymax_q[upd_lbl_i]) ymax_q[upd_lbl_i] <= upd_y_i;
      end
    end
  end

  assign rd_cnt_o  = cnt_q[rd_idx_i];
  assign rd_xmin_o = xmin_q[rd_idx_i];
  assign rd_xmax_o = xmax_q[rd_idx_i];
  assign rd_ymin_o = ymin_q[rd_idx_i];
  assign rd_ymax_o = ymax_q[rd_idx_i];

endmodule

// File: rtl/label_bbox_reader.sv
// Scans a raster label map, accumulates per-label boxes, then streams one
// record per non-empty label over a valid/ready handshake.
module label_bbox_reader
  import label_pkg::*;
#(
  parameter int PIC_COLS = DEF_PIC_COLS,
  parameter int PIC_ROWS = DEF_PIC_ROWS,
  parameter int LBL_W    = DEF_LBL_W,
  parameter int NLBL     = DEF_NLBL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LBL_W-1:0]  mem_rdata,
  output logic              box_valid,
  input  logic              box_ready,
  output logic [3:0]        box_label,
  output logic [X_W-1:0]    box_xmin,
  output logic [X_W-1:0]    box_xmax,
  output logic [Y_W-1:0]    box_ymin,
  output logic [Y_W-1:0]    box_ymax,
  output logic [CNT_W-1:0]  box_count,
  output logic              overflow
);

  localparam int                   NPIX      = PIC_COLS * PIC_ROWS;
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [X_W-1:0]       LAST_COL  = X_W'(PIC_COLS - 1);
  localparam logic [LBL_IDX_W-1:0] LAST_SLOT = LBL_IDX_W'(NLBL - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [X_W-1:0]       col_q, col_p1;
  logic [Y_W-1:0]       row_q, row_p1;
  logic                 rd_vld_q;
  logic                 ovf_q;
  logic [LBL_IDX_W-1:0] slot_q;

  logic                 start_acc, scan_last, slot_adv, lbl_hit, lbl_ovf, emit_act;
  logic [CNT_W-1:0]     tbl_cnt;
  logic [X_W-1:0]       tbl_xmin, tbl_xmax;
  logic [Y_W-1:0]       tbl_ymin, tbl_ymax;

  assign start_acc = (state_q == IDLE) && start;
  assign scan_last = (addr_q == LAST_ADDR);
  assign emit_act  = (state_q == EMIT);
  assign slot_adv  = (tbl_cnt == '0) || box_ready;
  assign lbl_hit   = rd_vld_q && (mem_rdata != LBL_W'(BG_LABEL)) && (mem_rdata < LBL_W'(NLBL));
  assign lbl_ovf   = rd_vld_q && (mem_rdata >= LBL_W'(NLBL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    if (slot_adv && (slot_q == LAST_SLOT)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    mem_rd    = (state_q == SCAN);
    box_valid = emit_act && (tbl_cnt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      slot_q   <= '0;
    end else begin
      rd_vld_q <= mem_rd;
      if (start_acc) begin
        addr_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
        ovf_q  <= 1'b0;
        slot_q <= LBL_IDX_W'(1);
      end else if (mem_rd) begin
        if (scan_last) begin
          addr_q <= '0;
          col_q  <= '0;
          row_q  <= '0;
        end else begin
          addr_q <= addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
      end
      if (lbl_ovf) ovf_q <= 1'b1;
      if (emit_act && slot_adv) slot_q <= slot_q + 1'b1;
    end
  end

  // Coordinates lag the address by one cycle to line up with mem_rdata.
  always_ff @(posedge clk) begin
    col_p1 <= col_q;
    row_p1 <= row_q;
  end

  label_bbox_table #(
    .NLBL    (NLBL),
    .CNT_MAX (NPIX)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_acc),
    .upd_i     (lbl_hit),
    .upd_lbl_i (mem_rdata[LBL_IDX_W-1:0]),
    .upd_x_i   (col_p1),
    .upd_y_i   (row_p1),
    .rd_idx_i  (slot_q),
    .rd_cnt_o  (tbl_cnt),
    .rd_xmin_o (tbl_xmin),
    .rd_xmax_o (tbl_xmax),
    .rd_ymin_o (tbl_ymin),
    .rd_ymax_o (tbl_ymax)
  );

  assign mem_addr  = addr_q;
  assign overflow  = ovf_q;
  assign box_label = box_valid ? 4'(slot_q) : '0;
  assign box_xmin  = box_valid ? tbl_xmin : '0;
  assign box_xmax  = box_valid ? tbl_xmax : '0;
  assign box_ymin  = box_valid ? tbl_ymin : '0;
  assign box_ymax  = box_valid ? tbl_ymax : '0;
  assign box_count = box_valid ? tbl_cnt : '0;

endmodule

// File: tb/tb_label_bbox_reader.sv
// Directed bench for label_bbox_reader on a reduced 40x16 map.
module tb_label_bbox_reader;

  localparam int COLS = 40;
  localparam int ROWS = 16;
  localparam int NPIX = COLS * ROWS;
  localparam int NL   = 16;

  typedef struct packed {
    logic [3:0]  lbl;
    logic [8:0]  xmin;
    logic [8:0]  xmax;
    logic [7:0]  ymin;
    logic [7:0]  ymax;
    logic [16:0] cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, mem_rd, box_valid, box_ready, overflow;
  logic [16:0] mem_addr, box_count;
  logic [31:0] mem_rdata;
  logic [3:0]  box_label;
  logic [8:0]  box_xmin, box_xmax;
  logic [7:0]  box_ymin, box_ymax;

  logic [31:0] mem [NPIX];
  rec_t        recs [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cyc, stab_err;
  logic [16:0] addr_c1, addr_cl;
  logic        rd_c1, rd_drain;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[9:0]];

  label_bbox_reader #(
    .PIC_COLS (COLS),
    .PIC_ROWS (ROWS),
    .LBL_W    (32),
    .NLBL     (NL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .box_valid (box_valid),
    .box_ready (box_ready),
    .box_label (box_label),
    .box_xmin  (box_xmin),
    .box_xmax  (box_xmax),
    .box_ymin  (box_ymin),
    .box_ymax  (box_ymax),
    .box_count (box_count),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 32'd0;
  endtask

  task automatic set_px(input int x, input int y, input logic [31:0] v);
    mem[y * COLS + x] = v;
  endtask

  task automatic chk_rec(input string tag, input int idx, input rec_t exp);
    if (idx < recs.size()) chk(tag, 32'(recs[idx]), 32'(exp));
    else chk({tag, "_missing"}, 32'(idx), 32'(recs.size()));
  endtask

  // Runs one scan; stall>0 holds box_ready low for that many cycles of the first record.
  task automatic do_scan(input int stall);
    int   cyc, held;
    rec_t r, hold_r;
    recs.delete();
    done_cyc = -1;
    stab_err = 0;
    held     = 0;
    hold_r   = '0;
    box_ready = (stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < NPIX + 200) begin
      if (cyc == 1) begin addr_c1 = mem_addr; rd_c1 = mem_rd; end
      if (cyc == NPIX) addr_cl = mem_addr;
      if (cyc == NPIX + 1) rd_drain = mem_rd;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (box_valid) begin
        r = '{box_label, box_xmin, box_xmax, box_ymin, box_ymax, box_count};
        if (recs.size() == 0 && held < stall) begin
          if (held == 0) hold_r = r;
          else if (r != hold_r) stab_err++;
          held++;
        end else begin
          if (stall > 0 && recs.size() == 0) begin
            if (r != hold_r) stab_err++;
            box_ready = 1'b1;
          end
          recs.push_back(r);
        end
      end
      tick();
      cyc++;
    end
    if (done_cyc < 0) chk("done_timeout", 32'(cyc), 32'(NPIX + NL + 1));
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ctl"}, {27'd0, done, mem_rd, box_valid, overflow, 1'b0}, 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_box"}, 32'(box_count) | 32'(box_label) | 32'(box_xmax) | 32'(box_ymax), 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; box_ready = 1'b0;
    clear_mem();
    tick(); tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    // All-zero map: no records, done after 15 empty slot skips.
    do_scan(0);
    chk("zero_nrec", 32'(recs.size()), 32'd0);
    chk("zero_done_cyc", 32'(done_cyc), 32'(NPIX + NL + 1));
    chk("zero_ovf", 32'(overflow), 32'd0);
    chk("addr_first", 32'(addr_c1), 32'd0);
    chk("rd_first", 32'(rd_c1), 32'd1);
    chk("addr_last", 32'(addr_cl), 32'(NPIX - 1));
    chk("rd_drain", 32'(rd_drain), 32'd0);

    // Rectangle of label 3.
    clear_mem();
    for (int y = 5; y <= 7; y++) for (int x = 10; x <= 20; x++) set_px(x, y, 32'd3);
    do_scan(0);
    chk("rect_nrec", 32'(recs.size()), 32'd1);
    chk_rec("rect_rec", 0, '{4'd3, 9'd10, 9'd20, 8'd5, 8'd7, 17'd33});

    // Opposite corners.
    clear_mem();
    set_px(0, 0, 32'd2);
    set_px(COLS - 1, ROWS - 1, 32'd7);
    do_scan(0);
    chk("corner_nrec", 32'(recs.size()), 32'd2);
    chk_rec("corner_rec0", 0, '{4'd2, 9'd0, 9'd0, 8'd0, 8'd0, 17'd1});
    chk_rec("corner_rec1", 1, '{4'd7, 9'(COLS - 1), 9'(COLS - 1), 8'(ROWS - 1), 8'(ROWS - 1), 17'd1});

    // Out-of-range label sets sticky overflow and is otherwise ignored.
    clear_mem();
    mem[100] = 32'd20;
    set_px(4, 4, 32'd1);
    do_scan(0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_nrec", 32'(recs.size()), 32'd1);
    chk_rec("ovf_rec", 0, '{4'd1, 9'd4, 9'd4, 8'd4, 8'd4, 17'd1});
    tick(); tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Back-pressure on the first of two records.
    clear_mem();
    for (int y = 5; y <= 7; y++) for (int x = 10; x <= 20; x++) set_px(x, y, 32'd3);
    set_px(30, 12, 32'd9);
    set_px(31, 12, 32'd9);
    do_scan(10);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("stall_stable", 32'(stab_err), 32'd0);
    chk("stall_nrec", 32'(recs.size()), 32'd2);
    chk_rec("stall_rec0", 0, '{4'd3, 9'd10, 9'd20, 8'd5, 8'd7, 17'd33});
    chk_rec("stall_rec1", 1, '{4'd9, 9'd30, 9'd31, 8'd12, 8'd12, 17'd2});

    // Reset in the middle of a scan, then a clean rerun.
    clear_mem();
    for (int y = 5; y <= 7; y++) for (int x = 10; x <= 20; x++) set_px(x, y, 32'd3);
    mem[100] = 32'd20;
    box_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (mem_addr != 17'd300 && guard < NPIX) begin
      tick();
      guard++;
    end
    chk("mid_reached", 32'(mem_addr), 32'd300);
    chk("mid_ovf_pre", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_zero("mid_rst_async");
    tick();
    chk_idle_zero("mid_rst_next");
    rst = 1'b0;
    tick();
    chk("mid_idle_busy", 32'(busy), 32'd0);
    do_scan(0);
    chk("rerun_nrec", 32'(recs.size()), 32'd1);
    chk_rec("rerun_rec", 0, '{4'd3, 9'd10, 9'd20, 8'd5, 8'd7, 17'd33});
    chk("rerun_ovf", 32'(overflow), 32'd1);
    chk("rerun_done_cyc", 32'(done_cyc), 32'(NPIX + NL + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
